inv_sub_bytes_seq: RTL and testbench

//   Sequential AES InvSubBytes stage. Sits directly downstream of InvShiftrows in the decryption

---
 rtl/inv_sub_bytes_seq.sv | 128 ++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// AES InvSubBytes stage: latches a 4x32 state, substitutes COLS_PER_CYC columns per clock
// through the inverse S-box, then holds the result under a valid/ready handshake.
module inv_sub_bytes_seq #(
  parameter int COLS_PER_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rowin1,
  input  logic [31:0] rowin2,
  input  logic [31:0] rowin3,
  input  logic [31:0] rowin4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rowout1,
  output logic [31:0] rowout2,
  output logic [31:0] rowout3,
  output logic [31:0] rowout4,
  output logic        busy
);

  localparam int N = 4 / COLS_PER_CYC;

  generate
    if (!(COLS_PER_CYC == 1 || COLS_PER_CYC == 2 || COLS_PER_CYC == 4)) begin : g_bad_cols
      $error("inv_sub_bytes_seq: COLS_PER_CYC must be 1, 2 or 4");
    end
  endgenerate

  // Inverse S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
    128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e,
    128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_86689816_d4a45ccc_5d65b692,
    128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
    128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
    128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
    128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1121059_2780ec5f,
    128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
    128'h172b047e_ba77d626_e1691463_55210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] msb;
    msb = {~b, 3'b111};
    return INV_SBOX[msb -: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, SUB, HOLD} state_e;

  state_e            state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic [3:0][31:0]  row_q, row_d;
  logic              last_col;

  // Last substitution cycle is the one whose group ends at column 3.
  assign last_col = (col_q == 2'((N - 1) * COLS_PER_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = SUB;
      SUB:     if (last_col)  state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE:    begin in_ready = 1'b1; busy = 1'b0; end
      HOLD:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Column c of a row sits at bits [31-8c -: 8], i.e. msb = {~c, 3'b111}.
  always_comb begin
    logic [1:0] c;
    c     = '0;
    row_d = row_q;
    col_d = col_q;
    if (state_q == IDLE && in_valid) begin
      row_d = {rowin1, rowin2, rowin3, rowin4};
      col_d = '0;
    end else if (state_q == SUB) begin
      for (int k = 0; k < COLS_PER_CYC; k++) begin
        c = col_q + 2'(k);
        for (int r = 0; r < 4; r++) begin
          row_d[r][{~c, 3'b111} -: 8] = inv_sbox(row_q[r][{~c, 3'b111} -: 8]);
        end
      end
      col_d = col_q + 2'(COLS_PER_CYC);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign rowout1 = row_q[3];
  assign rowout2 = row_q[2];
  assign rowout3 = row_q[1];
  assign rowout4 = row_q[0];

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq: one instance with one column per clock,
// one with four columns per clock.
module tb_inv_sub_bytes_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] rowin1, rowin2, rowin3, rowin4;
  logic [31:0] rowout1, rowout2, rowout3, rowout4;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [31:0] rowout1_4, rowout2_4, rowout3_4, rowout4_4;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  inv_sub_bytes_seq #(.COLS_PER_CYC(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rowin1(rowin1), .rowin2(rowin2), .rowin3(rowin3), .rowin4(rowin4),
    .out_valid(out_valid), .out_ready(out_ready),
    .rowout1(rowout1), .rowout2(rowout2), .rowout3(rowout3), .rowout4(rowout4),
    .busy(busy)
  );

  inv_sub_bytes_seq #(.COLS_PER_CYC(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .rowin1(rowin1), .rowin2(rowin2), .rowin3(rowin3), .rowin4(rowin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .rowout1(rowout1_4), .rowout2(rowout2_4), .rowout3(rowout3_4), .rowout4(rowout4_4),
    .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rows(input logic [31:0] a, b, c, d);
    rowin1 = a; rowin2 = b; rowin3 = c; rowin4 = d;
  endtask

  task automatic chk_rows(input string tag, input logic [31:0] a, b, c, d);
    chk({tag, "_r1"}, rowout1, a);
    chk({tag, "_r2"}, rowout2, b);
    chk({tag, "_r3"}, rowout3, c);
    chk({tag, "_r4"}, rowout4, d);
  endtask

  logic [31:0] held;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    set_rows(32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk_rows("rst", 0, 0, 0, 0);
    chk("rst4_in_ready", in_ready4, 1);
    tick();
    rst = 1'b0;
    tick();

    // All-zero block, one column per clock
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_in_ready", in_ready, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t1_early_valid", out_valid, 0);
    end
    tick();
    chk("t1_valid", out_valid, 1);
    chk_rows("t1", 32'h52525252, 32'h52525252, 32'h52525252, 32'h52525252);
    tick();
    chk("t1_valid_drop", out_valid, 0);
    chk("t1_ready_back", in_ready, 1);

    // Mixed pattern with backpressure in HOLD
    out_ready = 1'b0;
    set_rows(32'h637c0153, 32'hffed0000, 32'h63636363, 32'h63636363);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    set_rows(32'h0, 32'h0, 32'h0, 32'h0);
    for (int i = 1; i <= 4; i++) tick();
    chk("t2_valid", out_valid, 1);
    chk_rows("t2", 32'h00010950, 32'h7d535252, 32'h00000000, 32'h00000000);
    held = rowout2;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_in_ready", in_ready, 0);
      chk("t3_hold_row2", rowout2, held);
    end
    chk_rows("t3_after", 32'h00010950, 32'h7d535252, 32'h00000000, 32'h00000000);
    out_ready = 1'b1;
    tick();
    chk("t3_valid_drop", out_valid, 0);
    chk("t3_in_ready", in_ready, 1);

    // Back-to-back blocks with in_valid held high
    set_rows(32'h0, 32'h0, 32'h0, 32'h0);
    in_valid = 1'b1;
    tick();
    chk("t4_acc1", busy, 1);
    set_rows(32'h637c0153, 32'hffed0000, 32'h63636363, 32'h63636363);
    for (int i = 1; i <= 4; i++) tick();
    chk("t4_valid1", out_valid, 1);
    chk_rows("t4_blk1", 32'h52525252, 32'h52525252, 32'h52525252, 32'h52525252);
    tick();
    chk("t4_idle_gap", busy, 0);
    tick();
    chk("t4_acc2", busy, 1);
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) tick();
    chk("t4_early2", out_valid, 0);
    tick();
    chk("t4_valid2", out_valid, 1);
    chk_rows("t4_blk2", 32'h00010950, 32'h7d535252, 32'h00000000, 32'h00000000);
    tick();

    // Reset during the second SUB cycle
    set_rows(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_in_ready", in_ready, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_row1", rowout1, 0);
    tick();
    rst = 1'b0;
    set_rows(32'h637c0153, 32'hffed0000, 32'h63636363, 32'h63636363);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    chk("t5_valid", out_valid, 1);
    chk_rows("t5", 32'h00010950, 32'h7d535252, 32'h00000000, 32'h00000000);
    tick();

    // Four columns per clock
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    chk("t6_busy", busy4, 1);
    chk("t6_early", out_valid4, 0);
    tick();
    chk("t6_valid", out_valid4, 1);
    chk("t6_r1", rowout1_4, 32'h00010950);
    chk("t6_r2", rowout2_4, 32'h7d535252);
    chk("t6_r3", rowout3_4, 32'h00000000);
    chk("t6_r4", rowout4_4, 32'h00000000);
    tick();
    chk("t6_valid_drop", out_valid4, 0);
    chk("t6_in_ready", in_ready4, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
